// File: rtl/truth_sweep.sv
// Exhaustive truth-table sweeper: drives every input vector to a combinational block under test,
// samples its response once per vector and scores it against an expected table.
module truth_sweep #(
    parameter int N_IN = 4,
    parameter int HOLD = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 gray,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 resp,
    output logic [N_IN-1:0]      stim,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   captured,
    output logic [N_IN:0]        err_count,
    output logic                 first_err_valid,
    output logic [N_IN-1:0]      first_err_idx
);

    localparam int DEPTH = 2**N_IN;
    localparam int CW    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0]   LAST_CNT = CW'(HOLD - 1);
    localparam logic [N_IN-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [N_IN-1:0]   idx;
    logic [N_IN-1:0]   idx_next;
    logic [CW-1:0]     cnt;
    logic              gray_q;
    logic [DEPTH-1:0]  exp_q;
    logic              mismatch;
    logic [N_IN:0]     err_next;

    function automatic logic [N_IN-1:0] order(input logic [N_IN-1:0] i, input logic g);
        return g ? (i ^ (i >> 1)) : i;
    endfunction

    // err_next feeds both the counter and the final pass verdict so they always agree.
    always_comb begin
        idx_next = idx + 1'b1;
        mismatch = (resp != exp_q[stim]);
        err_next = err_count + {{N_IN{1'b0}}, mismatch};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            idx             <= '0;
            cnt             <= '0;
            gray_q          <= 1'b0;
            exp_q           <= '0;
            stim            <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            captured        <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (abort) begin
                        pass <= 1'b0;
                    end else if (start) begin
                        exp_q           <= expected;
                        gray_q          <= gray;
                        captured        <= '0;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_idx   <= '0;
                        pass            <= 1'b0;
                        idx             <= '0;
                        cnt             <= '0;
                        stim            <= order('0, gray);
                        busy            <= 1'b1;
                        state           <= RUN;
                    end
                end
                RUN: begin
                    // An abort wins over the sample due on the same edge.
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        pass  <= 1'b0;
                        stim  <= '0;
                        idx   <= '0;
                        cnt   <= '0;
                    end else if (cnt == LAST_CNT) begin
                        captured[stim] <= resp;
                        err_count      <= err_next;
                        if (mismatch && !first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_idx   <= stim;
                        end
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == '0);
                        end else begin
                            idx  <= idx_next;
                            cnt  <= '0;
                            stim <= order(idx_next, gray_q);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                    stim  <= '0;
                    idx   <= '0;
                    cnt   <= '0;
                    if (abort) begin
                        pass <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_sweep.sv
// Directed bench for truth_sweep: a 4-input/HOLD=5 instance and a 2-input/HOLD=1 instance,
// each driven by a behavioural lab block with optional injected faults.
module tb_truth_sweep;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_start, a_abort, a_gray, a_resp;
    logic [15:0] a_expected, a_model, a_fault;
    logic [3:0]  a_stim;
    logic        a_busy, a_done, a_pass;
    logic [15:0] a_captured;
    logic [4:0]  a_err_count;
    logic        a_first_err_valid;
    logic [3:0]  a_first_err_idx;

    logic        b_start, b_abort, b_gray, b_resp;
    logic [3:0]  b_expected, b_model;
    logic [1:0]  b_stim;
    logic        b_busy, b_done, b_pass;
    logic [3:0]  b_captured;
    logic [2:0]  b_err_count;
    logic        b_first_err_valid;
    logic [1:0]  b_first_err_idx;

    int tests = 0;
    int fails = 0;
    int cyc;
    logic seen_done;

    localparam logic [63:0] BIN_SEQ  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] GRAY_SEQ = 64'h0132_6754_CDFE_AB98;

    // Lab block models: correct truth table with optional per-vector inversions.
    assign a_resp = a_model[a_stim] ^ a_fault[a_stim];
    assign b_resp = b_model[b_stim];

    truth_sweep #(.N_IN(4), .HOLD(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .gray(a_gray),
        .expected(a_expected), .resp(a_resp), .stim(a_stim), .busy(a_busy), .done(a_done),
        .pass(a_pass), .captured(a_captured), .err_count(a_err_count),
        .first_err_valid(a_first_err_valid), .first_err_idx(a_first_err_idx)
    );

    truth_sweep #(.N_IN(2), .HOLD(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .gray(b_gray),
        .expected(b_expected), .resp(b_resp), .stim(b_stim), .busy(b_busy), .done(b_done),
        .pass(b_pass), .captured(b_captured), .err_count(b_err_count),
        .first_err_valid(b_first_err_valid), .first_err_idx(b_first_err_idx)
    );

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [15:0] exp_tbl, input logic [15:0] fault);
        a_expected = exp_tbl;
        a_fault    = fault;
    endtask

    // Starts a sweep on instance A, checks each vector's stim, returns edges from start to done.
    task automatic sweep_a(input logic g, input logic [63:0] seq, output int n);
        a_gray  = g;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        check_output("a_busy_after_start", a_busy, 1);
        check_output("a_pass_cleared", a_pass, 0);
        n = 0;
        while (!a_done && n < 200) begin
            if (n % 5 == 0 && n < 80)
                check_output($sformatf("a_stim_v%0d", n / 5), a_stim, seq[63 - 4*(n/5) -: 4]);
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_start = 0; a_abort = 0; a_gray = 0; a_model = 16'hF0C8;
        apply_stimulus(16'h0000, 16'h0000);
        b_start = 0; b_abort = 0; b_gray = 0; b_model = 4'b0110; b_expected = 4'b0110;

        #12;
        check_output("rst_stim", a_stim, 0);
        check_output("rst_busy", a_busy, 0);
        check_output("rst_done", a_done, 0);
        check_output("rst_pass", a_pass, 0);
        check_output("rst_captured", a_captured, 0);
        check_output("rst_err_count", a_err_count, 0);
        check_output("rst_first_err", {a_first_err_valid, a_first_err_idx}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Binary sweep against a correct block.
        apply_stimulus(16'hF0C8, 16'h0000);
        sweep_a(1'b0, BIN_SEQ, cyc);
        check_output("bin_done_cycles", cyc, 80);
        check_output("bin_busy_at_done", a_busy, 0);
        check_output("bin_pass", a_pass, 1);
        check_output("bin_err_count", a_err_count, 0);
        check_output("bin_captured", a_captured, 16'hF0C8);
        check_output("bin_first_err_valid", a_first_err_valid, 0);
        @(posedge clk); #1;
        check_output("bin_done_one_cycle", a_done, 0);
        check_output("bin_pass_held", a_pass, 1);

        // Binary sweep with vector A inverted.
        apply_stimulus(16'hF0C8, 16'h0400);
        sweep_a(1'b0, BIN_SEQ, cyc);
        check_output("fa_done_cycles", cyc, 80);
        check_output("fa_err_count", a_err_count, 1);
        check_output("fa_first_err_valid", a_first_err_valid, 1);
        check_output("fa_first_err_idx", a_first_err_idx, 4'hA);
        check_output("fa_pass", a_pass, 0);
        check_output("fa_captured", a_captured, 16'hF4C8);
        @(posedge clk); #1;

        // Gray sweep, correct block.
        apply_stimulus(16'hF0C8, 16'h0000);
        sweep_a(1'b1, GRAY_SEQ, cyc);
        check_output("gray_done_cycles", cyc, 80);
        check_output("gray_captured", a_captured, 16'hF0C8);
        check_output("gray_pass", a_pass, 1);
        @(posedge clk); #1;

        // Gray sweep with faults at 3 and 2; 3 comes first in Gray order.
        apply_stimulus(16'hF0C8, 16'h000C);
        sweep_a(1'b1, GRAY_SEQ, cyc);
        check_output("gf_err_count", a_err_count, 2);
        check_output("gf_first_err_idx", a_first_err_idx, 4'h3);
        check_output("gf_captured", a_captured, 16'hF0C4);
        check_output("gf_pass", a_pass, 0);
        @(posedge clk); #1;

        // Abort at edge 23 with a stray start over edges 10-12; faults at vectors 0 and 1.
        apply_stimulus(16'hF0C8, 16'h0003);
        a_gray  = 1'b0;
        a_start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 23; k++) begin
            a_start = (k >= 10 && k <= 12);
            a_abort = (k == 23);
            @(posedge clk); #1;
            if (k == 12) begin
                check_output("ab_stim_unaffected", a_stim, 4'h2);
                check_output("ab_busy_mid", a_busy, 1);
            end
        end
        a_start = 1'b0;
        a_abort = 1'b0;
        check_output("ab_busy", a_busy, 0);
        check_output("ab_done", a_done, 0);
        check_output("ab_pass", a_pass, 0);
        check_output("ab_stim", a_stim, 0);
        check_output("ab_err_count", a_err_count, 2);
        check_output("ab_captured", a_captured, 16'h000B);
        check_output("ab_first_err_idx", {a_first_err_valid, a_first_err_idx}, 5'h10);
        seen_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            seen_done = seen_done | a_done | a_busy;
        end
        check_output("ab_no_done_later", seen_done, 0);

        // Asynchronous reset mid-sweep, between edges.
        apply_stimulus(16'hF0C8, 16'h0001);
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("ar_busy", a_busy, 0);
        check_output("ar_stim", a_stim, 0);
        check_output("ar_captured", a_captured, 0);
        check_output("ar_err_count", a_err_count, 0);
        check_output("ar_first_err", {a_first_err_valid, a_first_err_idx}, 0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        apply_stimulus(16'hF0C8, 16'h0000);
        sweep_a(1'b0, BIN_SEQ, cyc);
        check_output("ar_fresh_cycles", cyc, 80);
        check_output("ar_fresh_pass", a_pass, 1);

        // HOLD=1, N_IN=2 instance with a back-to-back restart.
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        check_output("b_stim0", b_stim, 0);
        cyc = 0;
        while (!b_done && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) check_output("b_stim1", b_stim, 1);
        end
        check_output("b_done_cycles", cyc, 4);
        check_output("b_pass", b_pass, 1);
        check_output("b_captured", b_captured, 4'b0110);
        @(posedge clk); #1;
        check_output("b_done_cleared", b_done, 0);
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        check_output("b2_busy", b_busy, 1);
        cyc = 0;
        while (!b_done && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_output("b2_done_cycles", cyc, 4);
        check_output("b2_pass", b_pass, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
